// File: rtl/instr_fifo_hs.sv
// instr_fifo_hs: parametrised single-clock instruction FIFO with valid/ready
// handshakes on both sides. The head entry is visible on out_data whenever
// out_valid is high. Any DEPTH >= 2 is supported; pointers wrap explicitly at
// DEPTH-1, so the depth does not have to be a power of two. Status outputs are
// decoded from the registered occupancy count, so they never glitch.
module instr_fifo_hs #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned AF_THRESH  = 56,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [CW-1:0]         peak_count
);

  // Reject parameter values the counters and flags cannot represent.
  if (DEPTH < 2) begin : g_bad_depth
    $error("instr_fifo_hs: DEPTH must be at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $error("instr_fifo_hs: AF_THRESH must lie in 1..DEPTH");
  end

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_THRESH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

  // Storage is never reset; only the pointers and count define what is valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;

  // Advance a pointer by one, returning to zero after the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + AW'(1);
  endfunction

  // Handshake qualification and status decode from the registered count.
  always_comb begin
    in_ready    = (count != FULL_COUNT);
    out_valid   = (count != '0);
    almost_full = (count >= AF_COUNT);
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    count_nxt   = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // First-word-fall-through: the head entry is read combinationally.
  always_comb begin
    out_data = mem[rd_ptr];
  end

  // Storage write; a flush cycle performs no transfer.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, sticky overflow and high-water mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      peak_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      peak_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_nxt;
      if (in_valid && (count == FULL_COUNT)) begin
        overflow <= 1'b1;
      end
      if (count_nxt > peak_count) begin
        peak_count <= count_nxt;
      end
    end
  end

endmodule
